// File: rtl/midi_rx_parser_pkg.sv
// Shared MIDI types: message codes, note/controller event structs, parser state
// and byte-classification helpers.
package MIDI;

  localparam int BAUD_RATE = 31_250;

  typedef enum logic [3:0] {
    NOTE_OFF       = 4'h8,
    NOTE_ON        = 4'h9,
    CONTROL_CHANGE = 4'hB
  } msg_type_t;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } note_status_t;

  typedef enum logic [6:0] {
    FILTER_CUTOFF    = 7'd21,
    FILTER_RESONANCE = 7'd22,
    ATTACK           = 7'd24,
    DECAY            = 7'd25,
    SUSTAIN          = 7'd26,
    RELEASE          = 7'd27,
    LFO_RATE         = 7'd28
  } controller_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   note;
    logic [6:0]   velocity;
  } note_change_t;

  typedef struct packed {
    controller_t controller;
    logic [6:0]  value;
  } control_change_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parse_state_t;

  function automatic logic is_realtime(input logic [7:0] b);
    return b >= 8'hF8;
  endfunction

  function automatic logic is_channel_msg(input logic [3:0] nib);
    return (nib == NOTE_ON) || (nib == NOTE_OFF) || (nib == CONTROL_CHANGE);
  endfunction

  function automatic logic is_supported_controller(input logic [6:0] cc);
    case (cc)
      7'd21, 7'd22, 7'd24, 7'd25, 7'd26, 7'd27, 7'd28: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/midi_rx_parser_uart.sv
// 8N1 serial deframer for the MIDI line: synchronizer, mid-bit sampling,
// false-start rejection and framing-error recovery.
module midi_uart_rx
  import MIDI::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int TW         = $clog2(BIT_CYCLES + 1);

  typedef enum logic [2:0] {
    RX_WAIT_HIGH, RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  rx_state_t   state, nxt;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic [TW-1:0] timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        half_end, bit_end;
  logic        timer_clr, shift_en, byte_ok, byte_bad;

  assign rx_s     = sync_q[1];
  assign half_end = (timer == TW'(HALF - 1));
  assign bit_end  = (timer == TW'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_WAIT_HIGH;
    else        state <= nxt;
  end

  // The synchronizer's reset value is not a real line sample, so the line must
  // read high for three consecutive cycles before the receiver arms.
  always_comb begin
    nxt = state;
    case (state)
      RX_WAIT_HIGH: if (rx_s && timer == TW'(2)) nxt = RX_IDLE;
      RX_IDLE:      if (!rx_s) nxt = RX_START;
      RX_START:     if (half_end) nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (bit_end && bit_cnt == 3'd7) nxt = RX_STOP;
      RX_STOP:      if (bit_end) nxt = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      default:      nxt = RX_WAIT_HIGH;
    endcase
  end

  always_comb begin
    timer_clr = (nxt != state) || (state == RX_IDLE) ||
                (state == RX_DATA && bit_end) ||
                (state == RX_WAIT_HIGH && !rx_s);
    shift_en  = (state == RX_DATA) && bit_end;
    byte_ok   = (state == RX_STOP) && bit_end && rx_s;
    byte_bad  = (state == RX_STOP) && bit_end && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      timer         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], midi_rx};
      timer  <= timer_clr ? '0 : timer + TW'(1);
      if (shift_en) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_ok) byte_data <= shreg;
      byte_valid    <= byte_ok;
      framing_error <= byte_bad;
    end
  end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI channel-message parser: turns deframed bytes into note / controller
// strobes. Define MIDI_RUNNING_STATUS_EN to keep the status after each message.
module midi_rx_parser
  import MIDI::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            midi_rx,
  output note_change_t    note_change,
  output logic            note_change_valid,
  output control_change_t control_change,
  output logic            control_change_valid,
  output logic            framing_error
);

  logic [7:0]   rx_byte;
  logic         rx_valid;
  parse_state_t state, nxt;
  msg_type_t    msg_type;
  logic [6:0]   d1;
  logic         is_data, take_status, take_d1, emit, emit_note, emit_cc;
  note_change_t note_next;

  midi_uart_rx #(.CLK_FREQ(CLK_FREQ)) u_uart (
    .clk           (clk),
    .rst_n         (rst_n),
    .midi_rx       (midi_rx),
    .byte_data     (rx_byte),
    .byte_valid    (rx_valid),
    .framing_error (framing_error)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Real-time bytes are transparent: they never touch state or latched data.
  always_comb begin
    nxt = state;
    if (rx_valid && !is_realtime(rx_byte)) begin
      if (rx_byte[7]) begin
        nxt = is_channel_msg(rx_byte[7:4]) ? WAIT_D1 : IDLE;
      end else begin
        case (state)
          WAIT_D1: nxt = WAIT_D2;
`ifdef MIDI_RUNNING_STATUS_EN
          WAIT_D2: nxt = WAIT_D1;
`else
          WAIT_D2: nxt = IDLE;
`endif
          default: nxt = state;
        endcase
      end
    end
  end

  always_comb begin
    is_data     = rx_valid && !rx_byte[7];
    take_status = rx_valid && rx_byte[7] && !is_realtime(rx_byte) &&
                  is_channel_msg(rx_byte[7:4]);
    take_d1     = is_data && (state == WAIT_D1);
    emit        = is_data && (state == WAIT_D2);
    emit_note   = emit && (msg_type == NOTE_ON || msg_type == NOTE_OFF);
    emit_cc     = emit && (msg_type == CONTROL_CHANGE) && is_supported_controller(d1);
    note_next   = '{status:   (msg_type == NOTE_ON && rx_byte[6:0] != 7'd0) ? ON : OFF,
                    note:     d1,
                    velocity: rx_byte[6:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_type             <= NOTE_OFF;
      d1                   <= '0;
      note_change          <= '0;
      note_change_valid    <= 1'b0;
      control_change       <= '0;
      control_change_valid <= 1'b0;
    end else begin
      if (take_status) msg_type <= msg_type_t'(rx_byte[7:4]);
      if (take_d1)     d1 <= rx_byte[6:0];
      if (emit_note)   note_change <= note_next;
      if (emit_cc)     control_change <= '{controller: controller_t'(d1), value: rx_byte[6:0]};
      note_change_valid    <= emit_note;
      control_change_valid <= emit_cc;
    end
  end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Directed bench for midi_rx_parser: serial frames driven at 16 clocks/bit,
// strobes counted by a negedge monitor and compared to hand-computed values.
module tb_midi_rx_parser;
  import MIDI::*;

  localparam int CLK_F = 500_000;
  localparam int BIT   = CLK_F / 31_250;
  localparam int HALF  = BIT / 2;
  // Nominal: 2 sync flops + mid start + 9 bits to stop mid-sample + 2 latency.
  localparam int NOM_LAT = 2 + HALF + 9 * BIT + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            midi_rx = 1'b1;
  note_change_t    note_change;
  logic            note_change_valid;
  control_change_t control_change;
  logic            control_change_valid;
  logic            framing_error;

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_start = 0;
  int note_cnt = 0, cc_cnt = 0, fe_cnt = 0, both_cnt = 0, note_cyc = 0;
  note_change_t    note_last = '0;
  control_change_t cc_last = '0;

  midi_rx_parser #(.CLK_FREQ(CLK_F)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .midi_rx              (midi_rx),
    .note_change          (note_change),
    .note_change_valid    (note_change_valid),
    .control_change       (control_change),
    .control_change_valid (control_change_valid),
    .framing_error        (framing_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_change_valid) begin
      note_cnt  <= note_cnt + 1;
      note_last <= note_change;
      note_cyc  <= cyc;
    end
    if (control_change_valid) begin
      cc_cnt  <= cc_cnt + 1;
      cc_last <= control_change;
    end
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (note_change_valid && control_change_valid) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    midi_rx = v;
    wait_cyc(BIT);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    midi_rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic pulse_reset();
    midi_rx = 1'b1;
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(BIT);
  endtask

  int nb, cb, fb, lat;

  initial begin
    wait_cyc(4);
    chk("rst_note",       32'(note_change), 32'd0);
    chk("rst_note_valid", 32'(note_change_valid), 32'd0);
    chk("rst_cc",         32'(control_change), 32'd0);
    chk("rst_cc_valid",   32'(control_change_valid), 32'd0);
    chk("rst_fe",         32'(framing_error), 32'd0);
    rst_n = 1'b1;
    wait_cyc(BIT);

    // Note on, plus latency from the last start bit
    nb = note_cnt;
    send(8'h90); send(8'h3C); send(8'h64);
    wait_cyc(4);
    chk("on_count", 32'(note_cnt - nb), 32'd1);
    chk("on_value", 32'(note_last), 32'(note_change_t'{ON, 7'd60, 7'd100}));
    lat = note_cyc - last_start;
    chk("on_latency", 32'(lat >= NOM_LAT && lat <= NOM_LAT + 1), 32'd1);
    pulse_reset();

    nb = note_cnt;
    send(8'h90); send(8'h3C); send(8'h00);
    wait_cyc(4);
    chk("vel0_count", 32'(note_cnt - nb), 32'd1);
    chk("vel0_value", 32'(note_last), 32'(note_change_t'{OFF, 7'd60, 7'd0}));
    pulse_reset();

    nb = note_cnt;
    send(8'h80); send(8'h40); send(8'h20);
    wait_cyc(4);
    chk("off_count", 32'(note_cnt - nb), 32'd1);
    chk("off_value", 32'(note_last), 32'(note_change_t'{OFF, 7'd64, 7'd32}));
    pulse_reset();

    cb = cc_cnt;
    send(8'hB0); send(8'h18); send(8'h7F);
    wait_cyc(4);
    chk("cc_count", 32'(cc_cnt - cb), 32'd1);
    chk("cc_value", 32'(cc_last), 32'(control_change_t'{ATTACK, 7'd127}));
    pulse_reset();

    cb = cc_cnt;
    send(8'hB0); send(8'h17); send(8'h10);
    wait_cyc(4);
    chk("cc_unsupported", 32'(cc_cnt - cb), 32'd0);
    pulse_reset();

    // Running status pair
    nb = note_cnt;
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    wait_cyc(4);
`ifdef MIDI_RUNNING_STATUS_EN
    chk("rs_count", 32'(note_cnt - nb), 32'd2);
    chk("rs_value", 32'(note_last), 32'(note_change_t'{ON, 7'd62, 7'd80}));
`else
    chk("rs_count", 32'(note_cnt - nb), 32'd1);
    chk("rs_value", 32'(note_last), 32'(note_change_t'{ON, 7'd60, 7'd100}));
`endif
    pulse_reset();

    nb = note_cnt;
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    wait_cyc(4);
    chk("rt_count", 32'(note_cnt - nb), 32'd1);
    chk("rt_value", 32'(note_last), 32'(note_change_t'{ON, 7'd60, 7'd100}));
    pulse_reset();

    // Final data byte with a low stop bit
    nb = note_cnt; fb = fe_cnt;
    send(8'h90); send(8'h3C); send_frame(8'h64, 1'b0);
    wait_cyc(2 * BIT);
    chk("fe_count", 32'(fe_cnt - fb), 32'd1);
    chk("fe_no_note", 32'(note_cnt - nb), 32'd0);
    pulse_reset();

    // Reset in the middle of the first data byte
    nb = note_cnt;
    send(8'h90);
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
    rst_n = 1'b0;
    wait_cyc(3);
    midi_rx = 1'b1;
    rst_n = 1'b1;
    wait_cyc(2 * BIT);
    send(8'h64); send(8'h7F);
    wait_cyc(4);
    chk("rst_mid_no_note", 32'(note_cnt - nb), 32'd0);

    chk("never_both_valid", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/midi_rx_parser.md
# midi_rx_parser

Front end of the synthesizer's MIDI path. Receives the raw 31 250-baud MIDI serial line, deframes it into bytes, and assembles complete 3-byte channel messages. Emits one-cycle `note_change_t` and `control_change_t` strobes to the voice allocator and parameter registers. All message types and field widths come from the shared `MIDI` package.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz. Bit period is `BIT_CYCLES = CLK_FREQ / MIDI::BAUD_RATE`, which is 1600 at the default.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `midi_rx`, in, 1: asynchronous MIDI serial input. Idle high, 8N1, LSB first.
- `note_change`, out, `$bits(MIDI::note_change_t)`: last decoded note event. Held between strobes.
- `note_change_valid`, out, 1: one-cycle strobe; `note_change` is new.
- `control_change`, out, `$bits(MIDI::control_change_t)`: last decoded controller event. Held between strobes.
- `control_change_valid`, out, 1: one-cycle strobe.
- `framing_error`, out, 1: one-cycle strobe when a stop bit samples low.

## Operation
- Receiver:
  - `midi_rx` passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame. The start bit is re-sampled at `BIT_CYCLES/2`; if it reads high, the frame is a false start and the receiver returns to idle.
  - Eight data bits, then the stop bit, are each sampled at mid-bit.
  - Stop bit = 0: the byte is discarded, `framing_error` pulses, and the receiver waits for the line to be high before re-arming.
- Parser states: `IDLE` (no valid status), `WAIT_D1`, `WAIT_D2`.
- Status byte (bit 7 = 1):
  - 0xF8–0xFF (real-time): ignored in every state; state and latched data are unchanged.
  - Upper nibble ∈ {`NOTE_ON`, `NOTE_OFF`, `CONTROL_CHANGE`}: latch the type and go to `WAIT_D1`. The channel nibble is ignored (omni).
  - Any other status: go to `IDLE` and discard any partial message.
- Data byte (bit 7 = 0):
  - In `IDLE`: dropped.
  - In `WAIT_D1`: latch `data_byte1`, go to `WAIT_D2`.
  - In `WAIT_D2`: emit the message, go to `WAIT_D1` (see Configuration).
- Emit rules:
  - `NOTE_ON` with velocity ≠ 0: `status = ON`.
  - `NOTE_ON` with velocity = 0: `status = OFF`.
  - `NOTE_OFF`: `status = OFF`, velocity passed through unchanged.
  - `CONTROL_CHANGE`: emitted only if `data_byte1` equals a defined `controller_t` code (21, 22, 24–28). Otherwise the message is dropped silently, but the parser state still advances.
- Data fields are the 7-bit values taken from byte bits [6:0].

## Timing
- Reset values:
  - All outputs 0.
  - Parser `IDLE`, receiver idle.
  - Synchronizer flops reset to 1.
- Reset asserted mid-frame abandons the frame. The partial byte and message are never emitted.
- After reset, a start bit is accepted only after `midi_rx` has been seen high by the synchronizer.
- The internal byte strobe rises 1 cycle after the stop-bit mid-sample. `*_valid` rises 1 cycle after that, so latency is 2 cycles from the stop-bit sample of the final data byte.
- At most one of `note_change_valid` / `control_change_valid` is high in any cycle. Strobes are never back-to-back, because bytes are at least 10·`BIT_CYCLES` apart.
- No backpressure: consumers must accept every strobe.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: after an emit the parser returns to `WAIT_D1` with the type retained, so data-only pairs produce further messages.
- Macro undefined: after an emit the parser returns to `IDLE`, and every message must carry its own status byte.

## Structure
- Add to package `MIDI`:
  - `parse_state_t` enum (`IDLE`, `WAIT_D1`, `WAIT_D2`).
  - `is_realtime` and `is_supported_controller` functions.
- Sub-module `midi_uart_rx`, parameterised by `CLK_FREQ`:
  - Contains the synchronizer, bit timer and framing logic.
  - Outputs `byte_data[7:0]`, `byte_valid` and `framing_error`.
- `midi_rx_parser` instantiates `midi_uart_rx` and holds the parser FSM plus output registers.

## Test plan
- Send 0x90 0x3C 0x64 → one `note_change_valid` with {ON, 60, 100}, exactly 2 cycles after the last stop-bit sample.
- Send 0x90 0x3C 0x00 → {OFF, 60, 0}. Send 0x80 0x40 0x20 → {OFF, 64, 32}.
- Send 0xB0 0x18 0x7F → `control_change_valid` with {ATTACK, 127}. Send 0xB0 0x17 0x10 → no strobe.
- Send 0x90 0x3C 0x64 0x3E 0x50:
  - Macro on → second strobe {ON, 62, 80}.
  - Macro off → a single strobe only.
- Send 0x90 0x3C 0xF8 0x64 → {ON, 60, 100}, because the real-time byte is transparent.
- Two stimuli:
  - Frame with stop bit = 0 → `framing_error` pulses and no message is emitted.
  - Assert `rst_n` low during the first data byte, then send 0x64 → no strobe, because the parser is back in `IDLE`.
